ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite responder wrapping a word-organised register-file memory. It samples address phases on `hsel`/`hready` and drives the data phase with a fixed number of wait states. It returns read data, performs byte, halfword and word writes, and flags illegal transfers with a two-cycle ERROR response. Its `hrdata`/`hreadyout`/`hresp` outputs feed one slot of the slave-to-master response multiplexor.

## Interface
Parameters:
- `ADDR_W`, 8: log2 of memory depth in 32-bit words; local word index is `haddr[ADDR_W+1:2]`, upper bits ignored.
- `WAIT_STATES`, 1: wait cycles inserted in every OKAY data phase, range 0..15.

Ports:
- `hclk`  in  1  system clock, all logic on rising edge.
- `hreset`  in  1  synchronous, active-high reset.
- `hsel`  in  1  slave select from address decoder.
- `haddr`  in  32  transfer address.
- `htrans`  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  0 byte, 1 halfword, 2 word.
- `hwdata`  in  32  write data, valid in data phase.
- `hready`  in  1  bus-level ready from the multiplexor.
- `hrdata`  out  32  read data.
- `hreadyout`  out  1  this slave's ready.
- `hresp`  out  1  0 OKAY, 1 ERROR.

## Operation
- Accept an address phase when `hsel & hready & htrans[1]`. Register `haddr`, `hwrite`, `hsize`, and a legality flag.
- No accept when `htrans` is IDLE/BUSY or `hsel`=0. The next data phase is zero-wait OKAY with no side effects.
- Illegal transfers:
  - `hsize`>2;
  - halfword with `haddr[0]`=1;
  - word with `haddr[1:0]`≠0.
- FSM states:
  - IDLE: `hreadyout`=1, `hresp`=0.
  - WAIT: `hreadyout`=0, `hresp`=0; counts `WAIT_STATES` cycles.
  - DONE: `hreadyout`=1, `hresp`=0; completes the data phase.
  - ERR1: `hreadyout`=0, `hresp`=1.
  - ERR2: `hreadyout`=1, `hresp`=1.
- Transitions on accept:
  - legal: WAIT if `WAIT_STATES`>0, else DONE;
  - illegal: ERR1.
  - WAIT→DONE when the counter reaches `WAIT_STATES`.
  - ERR1→ERR2 unconditionally.
  - DONE/ERR2→IDLE, or directly into a new data phase if an accept occurs that cycle (back-to-back pipelining).
- Write in DONE: update only the addressed lanes at the clock edge ending the cycle.
  - byte: lane `haddr_q[1:0]`;
  - halfword: lanes 1:0 or 3:2 by `haddr_q[1]`;
  - word: all lanes.
- Read in DONE: `hrdata` = full 32-bit word `mem[index]`. The master extracts lanes.
- `hrdata` = 0 in every other state and for writes.
- Memory contents are not reset. Initial contents are undefined.

## Timing
- Reset values: state IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0, wait counter 0, captured address/control cleared.
- Reset asserted mid-transfer aborts it: no memory write, outputs at reset values next cycle.
- OKAY latency: data phase lasts `WAIT_STATES`+1 cycles after the accept edge.
- ERROR latency: always 2 cycles, independent of `WAIT_STATES`. `hresp`=1 is held in both error cycles. An illegal write never modifies memory.
- Read-after-write to the same word, back-to-back: the read returns the new data.
- Accept is blocked while `hready`=0. Address-phase inputs are not sampled in WAIT or ERR1.

## Configuration
- `AHB_SRAM_SLAVE_ERR_EN` defined: legality check, ERR1/ERR2 states and ERROR response compiled in, as above.
- Macro undefined:
  - no error states; `hresp` constant 0;
  - illegal transfers take the normal OKAY path with `WAIT_STATES` waits;
  - illegal writes are dropped; illegal reads return 0.

## Test plan
- `WAIT_STATES`=0: word write 0xDEADBEEF to 0x10, then read of 0x10 back-to-back → `hreadyout` never low; read data 0xDEADBEEF one cycle after the read accept.
- `WAIT_STATES`=2: word read of 0x20 → `hreadyout` 0,0,1 after accept; `hrdata` valid only in the third cycle.
- Word 0x11223344 at 0x30, then byte write 0xAA to 0x31, then halfword write 0x5566 to 0x32 → read 0x30 returns 0x5566AA44.
- Halfword write to 0x41 with the macro defined → `hreadyout`/`hresp` = 0/1 then 1/1; memory at 0x40 unchanged. With the macro undefined → OKAY, memory unchanged.
- Assert `hreset` during the WAIT of a write → next cycle `hreadyout`=1, `hresp`=0, target word unchanged.
- `hsel`=1 with `htrans`=IDLE, then BUSY → OKAY zero-wait, no memory access, `hrdata`=0.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder in front of a word-organised register
// file. Every OKAY data phase carries WAIT_STATES wait cycles; byte, halfword
// and word writes update only the addressed lanes.
// Optional feature macro: AHB_SRAM_SLAVE_ERR_EN. When it is defined, misaligned
// or oversized transfers get a two-cycle ERROR response. When it is undefined,
// they complete as OKAY, writes are dropped and reads return zero.
// o_dbg_state mirrors the FSM state so that checkers can observe it.
module ahb_sram_slave #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [2:0]  o_dbg_state
);

`ifdef AHB_SRAM_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_start_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W+1:0]   r_addr;
    logic                r_write;
    logic [2:0]          r_size;
    logic                r_legal;
    logic                r_hreadyout;
    logic                r_hresp;

    logic                w_open;
    logic                w_accept;
    logic                w_legal;
    logic [ADDR_W-1:0]   w_index;
    logic [31:0]         w_mask;
    logic [31:0]         w_rdword;
    logic                w_unused;

    logic [31:0]         r_mem [2**ADDR_W];

    // Address bits above the local word index and htrans[0] (SEQ vs NONSEQ)
    // do not affect this slave.
    assign w_unused = ^{haddr[31:ADDR_W+2], htrans[0]};

    // Legality of the transfer offered in the current address phase.
    always_comb begin
        w_legal = 1'b1;
        if (hsize > 3'd2) begin
            w_legal = 1'b0;
        end else if (hsize == 3'd1 && haddr[0]) begin
            w_legal = 1'b0;
        end else if (hsize == 3'd2 && haddr[1:0] != 2'b00) begin
            w_legal = 1'b0;
        end
    end

    // Accept is possible only when no data phase of ours is stalling the bus.
    always_comb begin
        w_open   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
        w_accept = w_open && hsel && hready && htrans[1];
        if (ERR_EN && !w_legal) begin
            w_start_state = S_ERR1;
        end else if (WS != 4'd0) begin
            w_start_state = S_WAIT;
        end else begin
            w_start_state = S_DONE;
        end
    end

    // Byte-lane enables of the captured transfer.
    always_comb begin
        w_mask = 32'h0000_0000;
        case (r_size)
            3'd0:    w_mask = 32'h0000_00FF << {r_addr[1:0], 3'b000};
            3'd1:    w_mask = r_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            3'd2:    w_mask = 32'hFFFF_FFFF;
            default: w_mask = 32'h0000_0000;
        endcase
    end

    assign w_index  = r_addr[ADDR_W+1:2];
    assign w_rdword = r_mem[w_index];

    // Transfer FSM: captures the address phase and registers ready/response.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= 3'd0;
            r_legal     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR2: begin
                    if (w_accept) begin
                        r_addr      <= haddr[ADDR_W+1:0];
                        r_write     <= hwrite;
                        r_size      <= hsize;
                        r_legal     <= w_legal;
                        r_state     <= w_start_state;
                        r_cnt       <= (w_start_state == S_WAIT) ? 4'd1 : 4'd0;
                        r_hreadyout <= (w_start_state == S_DONE);
                        r_hresp     <= (w_start_state == S_ERR1);
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == WS) begin
                        r_state     <= S_DONE;
                        r_cnt       <= 4'd0;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // Lane-masked write at the edge that ends a legal write data phase.
    // Memory contents are intentionally not reset.
    always_ff @(posedge hclk) begin
        if (!hreset && r_state == S_DONE && r_write && r_legal) begin
            r_mem[w_index] <= (w_rdword & ~w_mask) | (hwdata & w_mask);
        end
    end

    // Read data is presented only while a legal read completes.
    // It is taken straight from the array, so a read that follows a write
    // back-to-back sees the word that the write has just updated.
    assign hrdata      = (r_state == S_DONE && !r_write && r_legal) ? w_rdword : 32'h0000_0000;
    assign hreadyout   = r_hreadyout;
    assign hresp       = ERR_EN ? r_hresp : 1'b0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed bench for ahb_sram_slave. It drives two
// instances, one with zero wait states and one with two, behind a small
// bus-ready multiplexor. Expected read data is queued when a read is issued
// and is checked when the data phase completes.
module tb_ahb_sram_slave;

`ifdef AHB_SRAM_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel2;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic        owner = 1'b0;

    logic [31:0] hrdata0, hrdata2;
    logic        rdy0, rdy2, resp0, resp2;
    logic [2:0]  st0, st2;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl[int];

    // clock and bus-level ready
    always #5 hclk = ~hclk;

    assign hready = owner ? rdy2 : rdy0;

    always @(posedge hclk) begin
        if (hreset)
            owner <= 1'b0;
        else if (hready)
            owner <= hsel2;
    end

    ahb_sram_slave #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata(hrdata0), .hreadyout(rdy0), .hresp(resp0), .o_dbg_state(st0)
    );

    ahb_sram_slave #(.ADDR_W(8), .WAIT_STATES(2)) u_dut2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata(hrdata2), .hreadyout(rdy2), .hresp(resp2), .o_dbg_state(st2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] f_rdata(input int w);
        return (w == 2) ? hrdata2 : hrdata0;
    endfunction

    function automatic logic f_rdy(input int w);
        return (w == 2) ? rdy2 : rdy0;
    endfunction

    function automatic logic f_resp(input int w);
        return (w == 2) ? resp2 : resp0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic drive_idle();
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        haddr  = 32'h0;
    endtask

    task automatic addr_phase(input int w, input bit wr, input logic [2:0] sz, input logic [31:0] a);
        hsel0  = (w == 0);
        hsel2  = (w == 2);
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    // checks ready/response/read data in every cycle of one data phase
    task automatic data_phase(input int w, input bit wr, input logic [31:0] wd, input bit err,
                              input string tag);
        int ws = (w == 2) ? 2 : 0;
        int n  = err ? 2 : ws + 1;
        logic [31:0] e;
        hwdata = wd;
        for (int c = 0; c < n; c++) begin
            @(negedge hclk);
            check($sformatf("%s.rdy%0d", tag, c), 32'(f_rdy(w)), 32'(c == n - 1));
            check($sformatf("%s.resp%0d", tag, c), 32'(f_resp(w)), 32'(err));
            if (c == n - 1 && !wr && !err) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $error("FAIL %s.rdata observed=%08h expected=<none queued>", tag, f_rdata(w));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s.rdata", tag), f_rdata(w), e);
                end
            end else begin
                check($sformatf("%s.rdata%0d", tag, c), f_rdata(w), 32'h0);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    // one isolated transfer; an illegal one expects ERROR only with the feature on
    task automatic xfer(input int w, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit illegal, input logic [31:0] exp_rd,
                        input string tag);
        bit err = ERR_EN && illegal;
        addr_phase(w, wr, sz, a);
        if (!wr && !err)
            exp_q.push_back(exp_rd);
        @(posedge hclk);
        #1;
        drive_idle();
        data_phase(w, wr, wd, err, tag);
    endtask

    initial begin
        logic [31:0] a, d, e;

        // reset
        hreset = 1'b1;
        hwdata = 32'h0;
        drive_idle();
        repeat (3) @(posedge hclk);
        #1;
        @(negedge hclk);
        check("rst.rdy0", 32'(rdy0), 32'd1);
        check("rst.resp0", 32'(resp0), 32'd0);
        check("rst.rdata0", hrdata0, 32'h0);
        check("rst.state0", 32'(st0), 32'd0);
        check("rst.rdy2", 32'(rdy2), 32'd1);
        check("rst.resp2", 32'(resp2), 32'd0);
        check("rst.rdata2", hrdata2, 32'h0);
        check("rst.state2", 32'(st2), 32'd0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;

        // zero wait states: write then read of the same word back-to-back
        addr_phase(0, 1'b1, 3'd2, 32'h10);
        @(posedge hclk);
        #1;
        addr_phase(0, 1'b0, 3'd2, 32'h10);
        exp_q.push_back(32'hDEAD_BEEF);
        hwdata = 32'hDEAD_BEEF;
        @(negedge hclk);
        check("b2b.wr.rdy", 32'(rdy0), 32'd1);
        check("b2b.wr.resp", 32'(resp0), 32'd0);
        check("b2b.wr.rdata", hrdata0, 32'h0);
        @(posedge hclk);
        #1;
        drive_idle();
        hwdata = 32'h0;
        @(negedge hclk);
        check("b2b.rd.rdy", 32'(rdy0), 32'd1);
        check("b2b.rd.resp", 32'(resp0), 32'd0);
        e = exp_q.pop_front();
        check("b2b.rd.rdata", hrdata0, e);
        @(posedge hclk);
        #1;

        // two wait states: ready goes 0,0,1 and data appears in the last cycle
        xfer(2, 1'b1, 3'd2, 32'h20, 32'h0BAD_F00D, 1'b0, 32'h0, "ws2.wr");
        xfer(2, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h0BAD_F00D, "ws2.rd");

        // lane writes with junk in the unaddressed lanes
        xfer(0, 1'b1, 3'd2, 32'h30, 32'h1122_3344, 1'b0, 32'h0, "lane.word");
        xfer(0, 1'b1, 3'd0, 32'h31, 32'h7766_AA99, 1'b0, 32'h0, "lane.byte");
        xfer(0, 1'b1, 3'd1, 32'h32, 32'h5566_BBCC, 1'b0, 32'h0, "lane.half");
        xfer(0, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 32'h5566_AA44, "lane.rd");

        // illegal transfers leave memory untouched
        xfer(0, 1'b1, 3'd2, 32'h40, 32'hA5A5_A5A5, 1'b0, 32'h0, "ill0.init");
        xfer(0, 1'b1, 3'd1, 32'h41, 32'hFFFF_FFFF, 1'b1, 32'h0, "ill0.half");
        xfer(0, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'hA5A5_A5A5, "ill0.rd");
        xfer(2, 1'b1, 3'd2, 32'h44, 32'h0102_0304, 1'b0, 32'h0, "ill2.init");
        xfer(2, 1'b1, 3'd2, 32'h46, 32'hFFFF_FFFF, 1'b1, 32'h0, "ill2.word");
        xfer(2, 1'b0, 3'd3, 32'h44, 32'h0, 1'b1, 32'h0, "ill2.size");
        xfer(2, 1'b0, 3'd2, 32'h44, 32'h0, 1'b0, 32'h0102_0304, "ill2.rd");

        // reset during the wait of a write aborts it
        xfer(2, 1'b1, 3'd2, 32'h50, 32'h1234_5678, 1'b0, 32'h0, "rstw.init");
        addr_phase(2, 1'b1, 3'd2, 32'h50);
        @(posedge hclk);
        #1;
        drive_idle();
        hwdata = 32'hCAFE_F00D;
        @(negedge hclk);
        check("rstw.wait.rdy", 32'(rdy2), 32'd0);
        hreset = 1'b1;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("rstw.rdy", 32'(rdy2), 32'd1);
        check("rstw.resp", 32'(resp2), 32'd0);
        check("rstw.rdata", hrdata2, 32'h0);
        check("rstw.state", 32'(st2), 32'd0);
        @(posedge hclk);
        #1;
        xfer(2, 1'b0, 3'd2, 32'h50, 32'h0, 1'b0, 32'h1234_5678, "rstw.rd");

        // selected but IDLE, then BUSY: zero-wait OKAY, no memory access
        hsel0  = 1'b1;
        htrans = 2'b00;
        hwrite = 1'b1;
        hsize  = 3'd2;
        haddr  = 32'h10;
        hwdata = 32'hFFFF_FFFF;
        @(posedge hclk);
        #1;
        htrans = 2'b01;
        @(negedge hclk);
        check("idle.rdy", 32'(rdy0), 32'd1);
        check("idle.resp", 32'(resp0), 32'd0);
        check("idle.rdata", hrdata0, 32'h0);
        @(posedge hclk);
        #1;
        drive_idle();
        @(negedge hclk);
        check("busy.rdy", 32'(rdy0), 32'd1);
        check("busy.resp", 32'(resp0), 32'd0);
        check("busy.rdata", hrdata0, 32'h0);
        @(posedge hclk);
        #1;
        xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "busy.rd");

        // random word writes followed by read-back against a reference model
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(24, 255)) << 2;
            d = $urandom;
            mdl[int'(a)] = d;
            xfer(0, 1'b1, 3'd2, a, d, 1'b0, 32'h0, $sformatf("rnd.wr%0d", i));
        end
        foreach (mdl[k]) begin
            xfer(0, 1'b0, 3'd2, 32'(k), 32'h0, 1'b0, mdl[k], $sformatf("rnd.rd%0h", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
